// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: shared constants for the Gray-decode arbiter slice.
//   - FSM state encodings (IDLE / CONV / HOLD)
//   - default word width and requester count
package gray_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;  // waiting for any request
    localparam logic [1:0] CONV = 2'd1;  // captured word is being converted
    localparam logic [1:0] HOLD = 2'd2;  // result presented, waiting for accept

    localparam int DEF_W    = 4;
    localparam int DEF_NREQ = 4;

endpackage

// File: rtl/gray_to_bin_n.sv
// gray_to_bin_n: purely combinational W-bit Gray-to-binary converter.
// Ports:
//   gray - Gray-coded input word
//   bin  - binary equivalent
// Binary bit k is the XOR of all Gray bits from k up to the MSB, which is the
// unrolled form of b[k] = b[k+1] ^ g[k] with b[W-1] = g[W-1]. Writing it as a
// reduction per bit avoids a self-referencing vector.
module gray_to_bin_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int k = 0; k < W; k++) begin
            bin[k] = ^(gray >> k);
        end
    end

endmodule

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbiter sharing one Gray-to-binary
// converter among NREQ requesters.
// Ports:
//   CLK, RST_N  - clock (rising edge) and asynchronous active-low reset
//   REQ         - per-requester level-sensitive conversion request
//   GRAY_IN     - packed Gray words, lane i at [i*W +: W]
//   GNT         - one-hot, one-cycle pulse naming the captured requester
//   BUSY        - high whenever the FSM is outside IDLE
//   BIN_OT      - registered binary result
//   OT_ID       - requester index owning BIN_OT
//   OT_VALID    - result valid
//   OT_READY    - consumer accepts the result
//   STATE_DBG   - current FSM state (IDLE/CONV/HOLD encodings)
// Handshake: a result transfers on a rising edge where OT_VALID && OT_READY;
// while OT_VALID is high and OT_READY low, BIN_OT/OT_ID hold stable. OT_READY
// is ignored while OT_VALID is low.
module gray_decode_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] GRAY_IN,
    output logic [NREQ-1:0]   GNT,
    output logic              BUSY,
    output logic [W-1:0]      BIN_OT,
    output logic [IDW-1:0]    OT_ID,
    output logic              OT_VALID,
    input  logic              OT_READY,
    output logic [1:0]        STATE_DBG
);

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_q;
    logic [IDW-1:0] win_c;
    logic           found;
    int             idx;
    logic [W-1:0]   cap_q;
    logic [W-1:0]   conv_bin;
    logic [W-1:0]   lanes [NREQ];
    logic [IDW-1:0] ptr_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_lanes
        assign lanes[i] = GRAY_IN[i*W +: W];
    end

    // Round-robin pick: first set REQ bit searching upward from ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && REQ[idx[IDW-1:0]]) begin
                found = 1'b1;
                win_c = idx[IDW-1:0];
            end
        end
    end

    // Pointer moves past the accepted winner so it drops to lowest priority.
    assign ptr_next = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    gray_to_bin_n #(.W(W)) u_conv (
        .gray (cap_q),
        .bin  (conv_bin)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ptr      <= '0;
            win_q    <= '0;
            cap_q    <= '0;
            GNT      <= '0;
            BIN_OT   <= '0;
            OT_ID    <= '0;
            OT_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cap_q <= lanes[win_c];
                        win_q <= win_c;
                        GNT   <= {{(NREQ-1){1'b0}}, 1'b1} << win_c;
                        state <= CONV;
                    end
                end
                CONV: begin
                    GNT      <= '0;
                    BIN_OT   <= conv_bin;
                    OT_ID    <= win_q;
                    OT_VALID <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (OT_READY) begin
                        OT_VALID <= 1'b0;
                        ptr      <= ptr_next;
                        state    <= IDLE;
                    end
                end
                default: begin
                    GNT      <= '0;
                    OT_VALID <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign BUSY      = (state != IDLE);
    assign STATE_DBG = state;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb_gray_decode_arbiter: directed bench for gray_decode_arbiter with a
// result scoreboard (expected {id, bin} pushed at stimulus time, popped on
// each accepted result).
module tb_gray_decode_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              CLK;
    logic              RST_N;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*W-1:0] GRAY_IN;
    logic [NREQ-1:0]   GNT;
    logic              BUSY;
    logic [W-1:0]      BIN_OT;
    logic [IDW-1:0]    OT_ID;
    logic              OT_VALID;
    logic              OT_READY;
    logic [1:0]        STATE_DBG;

    logic [IDW+W-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    gray_decode_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .GRAY_IN   (GRAY_IN),
        .GNT       (GNT),
        .BUSY      (BUSY),
        .BIN_OT    (BIN_OT),
        .OT_ID     (OT_ID),
        .OT_VALID  (OT_VALID),
        .OT_READY  (OT_READY),
        .STATE_DBG (STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int k = W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v);
        GRAY_IN[i*W +: W] = v;
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] g);
        exp_q.push_back({IDW'(id), ref_g2b(g)});
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        exp_q.delete();
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge CLK) begin
        if (RST_N) begin
            chk("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
            chk("gnt_with_valid", 32'((GNT != '0) && OT_VALID), 32'd0);
            if (OT_VALID && OT_READY) begin
                chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [IDW+W-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_bin", 32'(BIN_OT), 32'(e[W-1:0]));
                    chk("sb_id", 32'(OT_ID), 32'(e[IDW+W-1:W]));
                end
            end
        end
    end

    // ---------------- directed steps ----------------
    initial begin
        logic [IDW-1:0] rr_ids [5];
        logic [W-1:0]   rr_lanes [NREQ];
        logic [W-1:0]   held_bin;
        logic [IDW-1:0] held_id;

        RST_N    = 1'b0;
        REQ      = '0;
        GRAY_IN  = '0;
        OT_READY = 1'b0;
        #2;
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_bin", 32'(BIN_OT), 32'd0);
        chk("rst_id", 32'(OT_ID), 32'd0);
        chk("rst_valid", 32'(OT_VALID), 32'd0);
        chk("rst_state", 32'(STATE_DBG), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Single request on lane 1.
        set_lane(1, 4'b0110);
        REQ      = 4'b0010;
        OT_READY = 1'b1;
        push_exp(1, 4'b0110);
        tick();
        chk("single_gnt", 32'(GNT), 32'b0010);
        chk("single_busy", 32'(BUSY), 32'd1);
        chk("single_novalid", 32'(OT_VALID), 32'd0);
        REQ = '0;
        tick();
        chk("single_gnt_drop", 32'(GNT), 32'd0);
        chk("single_valid", 32'(OT_VALID), 32'd1);
        chk("single_bin", 32'(BIN_OT), 32'b0100);
        chk("single_id", 32'(OT_ID), 32'd1);
        tick();
        chk("single_valid_drop", 32'(OT_VALID), 32'd0);
        chk("single_idle", 32'(BUSY), 32'd0);

        // All requesters, round robin from pointer 0.
        do_reset();
        rr_lanes[0] = 4'b1000;
        rr_lanes[1] = 4'b0110;
        rr_lanes[2] = 4'b0011;
        rr_lanes[3] = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_lane(i, rr_lanes[i]);
        rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd2; rr_ids[3] = 2'd3; rr_ids[4] = 2'd0;
        REQ      = 4'b1111;
        OT_READY = 1'b1;
        for (int n = 0; n < 5; n++) begin
            push_exp(int'(rr_ids[n]), rr_lanes[rr_ids[n]]);
            tick();
            chk("rr_gnt", 32'(GNT), 32'(4'b0001 << rr_ids[n]));
            if (n == 4) REQ = '0;
            tick();
            chk("rr_gnt_gap", 32'(GNT), 32'd0);
            chk("rr_id", 32'(OT_ID), 32'(rr_ids[n]));
            tick();
            chk("rr_valid_drop", 32'(OT_VALID), 32'd0);
        end

        // Backpressure: pointer is now 1.
        REQ      = 4'b1111;
        OT_READY = 1'b0;
        push_exp(1, rr_lanes[1]);
        tick();
        chk("bp_gnt", 32'(GNT), 32'b0010);
        tick();
        chk("bp_valid", 32'(OT_VALID), 32'd1);
        held_bin = BIN_OT;
        held_id  = OT_ID;
        chk("bp_bin", 32'(BIN_OT), 32'b0100);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_bin", 32'(BIN_OT), 32'(held_bin));
            chk("bp_hold_id", 32'(OT_ID), 32'(held_id));
            chk("bp_hold_valid", 32'(OT_VALID), 32'd1);
            chk("bp_no_gnt", 32'(GNT), 32'd0);
            chk("bp_state", 32'(STATE_DBG), 32'd2);
        end
        OT_READY = 1'b1;
        push_exp(2, rr_lanes[2]);
        tick();
        chk("bp_accept_valid", 32'(OT_VALID), 32'd0);
        chk("bp_accept_gnt", 32'(GNT), 32'd0);
        chk("bp_accept_idle", 32'(BUSY), 32'd0);
        tick();
        chk("bp_next_gnt", 32'(GNT), 32'b0100);
        REQ = '0;
        tick();
        tick();

        // Withdrawn request: REQ[2] low again before the sampling edge.
        REQ = 4'b0100;
        #3;
        REQ = '0;
        tick();
        chk("wd_no_gnt", 32'(GNT), 32'd0);
        chk("wd_no_busy", 32'(BUSY), 32'd0);
        tick();
        chk("wd_no_valid", 32'(OT_VALID), 32'd0);

        // Reset while in CONV; pointer is 3 beforehand.
        REQ = 4'b1100;
        tick();
        chk("mr_pre_gnt", 32'(GNT), 32'b1000);
        chk("mr_pre_state", 32'(STATE_DBG), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mr_gnt", 32'(GNT), 32'd0);
        chk("mr_busy", 32'(BUSY), 32'd0);
        chk("mr_valid", 32'(OT_VALID), 32'd0);
        chk("mr_bin", 32'(BIN_OT), 32'd0);
        chk("mr_id", 32'(OT_ID), 32'd0);
        exp_q.delete();
        tick();
        chk("mr_hold_valid", 32'(OT_VALID), 32'd0);
        RST_N = 1'b1;
        push_exp(2, rr_lanes[2]);
        tick();
        chk("mr_post_gnt", 32'(GNT), 32'b0100);
        REQ = '0;
        tick();
        chk("mr_post_bin", 32'(BIN_OT), 32'b0010);
        tick();

        // Exhaustive lane-0 sweep with random traffic on idle lanes.
        OT_READY = 1'b1;
        for (int v = 0; v < (1 << W); v++) begin
            for (int i = 1; i < NREQ; i++) set_lane(i, W'($urandom_range(0, (1 << W) - 1)));
            set_lane(0, W'(v));
            REQ = 4'b0001;
            push_exp(0, W'(v));
            tick();
            chk("sw_gnt", 32'(GNT), 32'b0001);
            REQ = '0;
            tick();
            chk("sw_bin", 32'(BIN_OT), 32'(ref_g2b(W'(v))));
            chk("sw_id", 32'(OT_ID), 32'd0);
            tick();
        end

        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
